prog_loader: RTL
================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, meaning clock cycles per serial bit (50 MHz / 115200 baud).
REQ-002 Parameter ADDR_W, default 16, meaning width of the byte address written to instruction memory.
REQ-003 clock  input  1  single system clock; all logic SHALL be clocked on its rising edge only.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 enable  input  1  load mode; the CPU is held in reset externally while high.
REQ-006 rx  input  1  asynchronous UART serial line, idle high, 8N1, LSB first.
REQ-007 wr_en  output  1  one-cycle write strobe to instruction memory.
REQ-008 wr_addr  output  ADDR_W  byte address of the word being written, always a multiple of 4.
REQ-009 wr_data  output  32  assembled instruction word.
REQ-010 busy  output  1  high while a serial frame is in progress or a partial word is held.
REQ-011 word_count  output  16  number of words written since the last enable rising edge.
REQ-012 frame_err  output  1  sticky flag: a received stop bit was low.

Function
REQ-013 rx SHALL pass through a 2-flop synchronizer before any use; its latency is not observable at the outputs beyond 2 cycles.
REQ-014 The receiver FSM SHALL have states IDLE, START, DATA, STOP.
REQ-015 IDLE -> START on a synchronized falling edge of rx, only while enable=1.
REQ-016 In START, sample at CLKS_PER_BIT/2 cycles: rx=0 -> DATA; rx=1 -> IDLE (glitch rejected, no byte).
REQ-017 DATA SHALL sample 8 bits at CLKS_PER_BIT spacing, LSB first, then go to STOP.
REQ-018 STOP SHALL sample after CLKS_PER_BIT: rx=1 -> byte valid; rx=0 -> byte discarded, frame_err set. Either case -> IDLE.
REQ-019 Valid bytes SHALL be packed big-endian: 1st byte -> wr_data[31:24], 4th byte -> wr_data[7:0].
REQ-020 On the clock after the 4th valid byte, wr_en SHALL pulse high for exactly one cycle with wr_data and wr_addr stable during that cycle.
REQ-021 After each write, wr_addr SHALL increment by 4 and word_count by 1; wr_addr wraps from the maximum multiple of 4 to 0; word_count saturates at 16'hFFFF.
REQ-022 A rising edge of enable SHALL clear wr_addr, word_count, the byte counter, and frame_err.
REQ-023 enable falling mid-frame or mid-word SHALL abort: FSM -> IDLE, the partial word is discarded, no wr_en, and wr_addr/word_count are held.
REQ-024 A frame error SHALL NOT advance the byte counter; subsequent bytes continue filling the same word.
REQ-025 wr_en SHALL never assert while enable=0.
REQ-026 busy = (FSM != IDLE) OR (byte counter != 0).

Reset
REQ-027 On reset=1 at a rising clock edge: FSM=IDLE, wr_en=0, wr_addr=0, wr_data=0, word_count=0, busy=0, frame_err=0, byte counter=0, synchronizer flops=1.
REQ-028 Reset SHALL take priority over enable edges and over any in-progress frame; a frame in progress is dropped.

Structure
REQ-029 The shared package SHALL hold the FSM state encoding (2-bit) and the default CLKS_PER_BIT constant.
REQ-030 The serial front end (synchronizer, FSM, bit timer) SHALL be a sub-module named uart_rx, outputting a byte plus a one-cycle valid and a frame-error pulse; prog_loader SHALL do word assembly and addressing.

Verification
REQ-031 enable=1, send bytes 0x20,0x08,0x00,0x05 -> single wr_en pulse, wr_data=32'h20080005, wr_addr=0, then word_count=1, wr_addr=4.
REQ-032 Send 8 bytes forming 0x8C010000 then 0xAC020004 -> two pulses at addr 0 and 4, word_count=2, busy=0 after.
REQ-033 rx low pulse of CLKS_PER_BIT/4 cycles -> no byte, no wr_en, FSM back to IDLE, busy=0.
REQ-034 Byte with stop bit forced 0, followed by 4 good bytes 0x11,0x22,0x33,0x44 -> frame_err=1, one write of 32'h11223344.
REQ-035 Send 2 bytes, drop enable, raise enable, send 4 bytes 0xDE,0xAD,0xBE,0xEF -> only one write, 32'hDEADBEEF at addr 0, frame_err=0.
REQ-036 Assert reset during DATA of the 3rd byte -> all outputs at reset values the next cycle; next 4 bytes produce a write at addr 0.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the serial program loader.
package prog_loader_pkg;

  localparam int unsigned CLKS_PER_BIT_DEFAULT = 434;
  localparam int unsigned BYTES_PER_WORD       = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StData  = 2'd2,
    StStop  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/prog_loader_if.sv
// Instruction-memory write port driven by the loader.
interface prog_loader_if #(
  parameter int unsigned ADDR_W = 16
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;

  modport master (output wr_en, output wr_addr, output wr_data);
  modport slave  (input  wr_en, input  wr_addr, input  wr_data);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizer, bit timer and frame FSM; emits one-cycle byte/error pulses.
module uart_rx
  import prog_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       rx_busy
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] FullLast = CntW'(CLKS_PER_BIT - 1);

  logic            rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CntW'(1);
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (rx_prev_q && !rx_sync_q) state_d = StStart;
      end
      StStart: begin
        // Mid-start-bit sample: a high line here was only a glitch.
        if (cnt_q == HalfLast) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rx_sync_q ? StIdle : StData;
        end
      end
      StData: begin
        if (cnt_q == FullLast) begin
          cnt_d     = '0;
          shift_d   = {rx_sync_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = StStop;
        end
      end
      StStop: begin
        if (cnt_q == FullLast) begin
          cnt_d   = '0;
          valid_d = rx_sync_q;
          err_d   = !rx_sync_q;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (!enable) begin
      state_d = StIdle;
      cnt_d   = '0;
      valid_d = 1'b0;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  assign rx_byte      = shift_q;
  assign rx_valid     = valid_q;
  assign rx_frame_err = err_q;
  assign rx_busy      = (state_q != StIdle);

endmodule

// File: rtl/prog_loader.sv
// Serial program loader: packs received bytes big-endian into words and writes them to
// sequential instruction-memory addresses while enable is high.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int unsigned ADDR_W       = 16
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           enable,
  input  logic           rx,
  prog_loader_if.master  mem,
  output logic           busy,
  output logic [15:0]    word_count,
  output logic           frame_err
);

  logic [7:0] rx_byte;
  logic       rx_valid, rx_err, rx_busy;

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_rx (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .rx          (rx),
    .rx_byte     (rx_byte),
    .rx_valid    (rx_valid),
    .rx_frame_err(rx_err),
    .rx_busy     (rx_busy)
  );

  logic              en_prev_q;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [23:0]       word_q, word_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]       wr_data_q, wr_data_d;
  logic [15:0]       word_count_q, word_count_d;
  logic              frame_err_q, frame_err_d;
  logic              en_rise, wr_fire;

  assign en_rise = enable & ~en_prev_q;
  assign wr_fire = wr_en_q & enable;

  always_comb begin
    byte_cnt_d   = byte_cnt_q;
    word_d       = word_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    word_count_d = word_count_q;
    frame_err_d  = frame_err_q | rx_err;
    // Address/count advance after the strobe so they stay stable during it.
    if (wr_fire) begin
      wr_addr_d = wr_addr_q + ADDR_W'(4);
      if (word_count_q != 16'hFFFF) word_count_d = word_count_q + 16'd1;
    end
    if (rx_valid) begin
      if (byte_cnt_q == 2'(BYTES_PER_WORD - 1)) begin
        wr_data_d  = {word_q, rx_byte};
        wr_en_d    = 1'b1;
        byte_cnt_d = '0;
      end else begin
        word_d     = {word_q[15:0], rx_byte};
        byte_cnt_d = byte_cnt_q + 2'd1;
      end
    end
    if (!enable) begin
      byte_cnt_d = '0;
      wr_en_d    = 1'b0;
    end
    if (en_rise) begin
      wr_addr_d    = '0;
      word_count_d = '0;
      byte_cnt_d   = '0;
      frame_err_d  = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      en_prev_q    <= 1'b0;
      byte_cnt_q   <= '0;
      word_q       <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      word_count_q <= '0;
      frame_err_q  <= 1'b0;
    end else begin
      en_prev_q    <= enable;
      byte_cnt_q   <= byte_cnt_d;
      word_q       <= word_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      word_count_q <= word_count_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign mem.wr_en   = wr_fire;
  assign mem.wr_addr = wr_addr_q;
  assign mem.wr_data = wr_data_q;
  assign busy        = rx_busy | (byte_cnt_q != 2'd0);
  assign word_count  = word_count_q;
  assign frame_err   = frame_err_q;

endmodule
